// File: rtl/instruction_mem_responder.sv
// Instruction memory responder: fixed-latency single-outstanding fetch port.
// Optional misaligned-address reporting is enabled by defining MISALIGN_CHECK_EN.
module instruction_mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 128
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  input  logic [31:0] ReqAddr,
  output logic        ReqReady,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespData,
  output logic        RespErr,
  input  logic        LoadEn,
  input  logic [31:0] LoadAddr,
  input  logic [31:0] LoadData
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic accept;
  logic misalign;
  logic [31:0] data_q;

  // Power-up contents are zero; reset never touches the array.
  logic [31:0] mem [DEPTH] = '{default: 32'h0};

  logic [AW-1:0] ridx;
  logic [AW-1:0] widx;
  assign ridx = ReqAddr[AW+1:2];
  assign widx = LoadAddr[AW+1:2];

`ifdef MISALIGN_CHECK_EN
  logic err_q;
  logic unused_addr;
  assign misalign = |ReqAddr[1:0];
  assign RespErr = err_q;
  assign unused_addr = ^{ReqAddr[31:AW+2], LoadAddr[31:AW+2],
                         LoadAddr[1:0]};
`else
  logic unused_addr;
  assign misalign = 1'b0;
  assign RespErr = 1'b0;
  assign unused_addr = ^{ReqAddr[31:AW+2], ReqAddr[1:0],
                         LoadAddr[31:AW+2], LoadAddr[1:0]};
`endif

  assign RespData = data_q;

  // Next-state, latency countdown and handshake outputs.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    accept    = 1'b0;
    ReqReady  = 1'b0;
    RespValid = 1'b0;
    unique case (state)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          accept  = 1'b1;
          state_n = WAIT;
          cnt_n   = LAT_M1;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_n = RESP;
        else cnt_n = cnt - 4'd1;
      end
      RESP: begin
        RespValid = 1'b1;
        if (RespReady) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; response word is captured at the acceptance edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      data_q <= 32'h0;
`ifdef MISALIGN_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        data_q <= misalign ? 32'h0 : mem[ridx];
`ifdef MISALIGN_CHECK_EN
        err_q  <= misalign;
`endif
      end
    end
  end

  // Program-load port; writes regardless of FSM state or reset.
  always_ff @(posedge Clk) begin
    if (LoadEn) mem[widx] <= LoadData;
  end

endmodule

// File: tb/tb_instruction_mem_responder.sv
// Randomised bench for instruction_mem_responder with a timing-level model.
// Directed literal checks pin the model on the key scenarios first.
module tb_instruction_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 128;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0;
  logic [31:0] ReqAddr = 32'h0;
  logic        ReqReady;
  logic        RespValid;
  logic        RespReady = 1'b0;
  logic [31:0] RespData;
  logic        RespErr;
  logic        LoadEn = 1'b0;
  logic [31:0] LoadAddr = 32'h0;
  logic [31:0] LoadData = 32'h0;

  instruction_mem_responder #(
    .LATENCY(LAT),
    .DEPTH(DEPTH)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ReqValid(ReqValid),
    .ReqAddr(ReqAddr),
    .ReqReady(ReqReady),
    .RespValid(RespValid),
    .RespReady(RespReady),
    .RespData(RespData),
    .RespErr(RespErr),
    .LoadEn(LoadEn),
    .LoadAddr(LoadAddr),
    .LoadData(LoadData)
  );

  always #5 Clk = ~Clk;

`ifdef MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Model: a pending fetch is "busy" with a due edge; data taken at accept.
  logic [31:0] m_mem [DEPTH];
  bit          m_busy = 0;
  int          m_due = 0;
  int          cyc = 0;
  logic [31:0] m_data = 32'h0;
  bit          m_err = 0;
  bit          m_live = 0;
  bit          m_rst_last = 0;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

  always @(posedge Clk) begin
    cyc = cyc + 1;
    m_rst_last = Reset;
    if (Reset) begin
      m_busy = 0;
      m_data = 32'h0;
      m_err  = 0;
      m_live = 1;
    end else if (!m_busy && ReqValid) begin
      m_busy = 1;
      m_due  = cyc + LAT;
      m_err  = CHK_EN && (ReqAddr % 4 != 0);
      m_data = m_err ? 32'h0 : m_mem[(ReqAddr / 4) % DEPTH];
    end else if (m_busy && cyc > m_due && RespReady) begin
      m_busy = 0;
    end
    if (LoadEn) m_mem[(LoadAddr / 4) % DEPTH] = LoadData;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Continuous comparison against the model.
  always @(negedge Clk) begin
    if (m_live) begin
      logic ev;
      ev = m_busy && (cyc >= m_due);
      chk("model ReqReady", 32'(ReqReady), 32'(!m_busy));
      chk("model RespValid", 32'(RespValid), 32'(ev));
      if (ev || m_rst_last) begin
        chk("model RespData", RespData, m_data);
        chk("model RespErr", 32'(RespErr), 32'(m_err));
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] ed,
                       input logic ee, input string nm);
    ReqValid  = 1'b1;
    ReqAddr   = a;
    RespReady = 1'b1;
    @(negedge Clk);
    ReqValid = 1'b0;
    LoadEn   = 1'b0;
    chk({nm, " accepted"}, 32'(ReqReady), 32'd0);
    chk({nm, " wait"}, 32'(RespValid), 32'd0);
    for (int i = 1; i < LAT; i++) begin
      @(negedge Clk);
      chk({nm, " wait"}, 32'(RespValid), 32'd0);
    end
    @(negedge Clk);
    chk({nm, " valid"}, 32'(RespValid), 32'd1);
    chk({nm, " data"}, RespData, ed);
    chk({nm, " err"}, 32'(RespErr), 32'(ee));
    @(negedge Clk);
    chk({nm, " idle"}, 32'(ReqReady), 32'd1);
    chk({nm, " drop"}, 32'(RespValid), 32'd0);
  endtask

  initial begin
    // Reset for two edges with a request already presented.
    ReqValid = 1'b1;
    ReqAddr  = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("rst RespValid", 32'(RespValid), 32'd0);
      chk("rst RespData", RespData, 32'h0);
      chk("rst RespErr", 32'(RespErr), 32'd0);
    end
    Reset = 1'b0;
    chk("release ReqReady", 32'(ReqReady), 32'd1);
    @(negedge Clk);
    ReqValid  = 1'b0;
    RespReady = 1'b1;
    repeat (LAT + 2) @(negedge Clk);

    // Load then fetch with full-rate consumer.
    LoadEn   = 1'b1;
    LoadAddr = 32'h4;
    LoadData = 32'h2010_0005;
    @(negedge Clk);
    LoadEn = 1'b0;
    fetch(32'h4, 32'h2010_0005, 1'b0, "basic");

    // Back-pressured response; request to 0x8 held meanwhile.
    ReqValid  = 1'b1;
    ReqAddr   = 32'h4;
    RespReady = 1'b0;
    @(negedge Clk);
    ReqAddr = 32'h8;
    @(negedge Clk);
    chk("bp wait", 32'(RespValid), 32'd0);
    @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", 32'(RespValid), 32'd1);
      chk("bp data", RespData, 32'h2010_0005);
      chk("bp ReqReady", 32'(ReqReady), 32'd0);
      @(negedge Clk);
    end
    RespReady = 1'b1;
    chk("bp still valid", 32'(RespValid), 32'd1);
    @(negedge Clk);
    chk("bp idle", 32'(ReqReady), 32'd1);
    chk("bp drop", 32'(RespValid), 32'd0);
    @(negedge Clk);
    chk("bp 2nd accepted", 32'(ReqReady), 32'd0);
    ReqValid = 1'b0;
    repeat (LAT) @(negedge Clk);
    chk("bp 2nd data", RespData, 32'h0);
    @(negedge Clk);

    // Load and request to the same word in the same cycle.
    LoadEn   = 1'b1;
    LoadAddr = 32'h8;
    LoadData = 32'hAAAA_5555;
    fetch(32'h8, 32'h0, 1'b0, "same-cycle old");
    fetch(32'h8, 32'hAAAA_5555, 1'b0, "same-cycle new");

    // Reset while waiting discards the response.
    ReqValid = 1'b1;
    ReqAddr  = 32'h4;
    @(negedge Clk);
    ReqValid = 1'b0;
    Reset    = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("wait-rst ReqReady", 32'(ReqReady), 32'd1);
    for (int i = 0; i < LAT + 2; i++) begin
      chk("wait-rst RespValid", 32'(RespValid), 32'd0);
      @(negedge Clk);
    end
    fetch(32'h4, 32'h2010_0005, 1'b0, "after rst");

    // Misaligned request and address aliasing.
    fetch(32'h6, CHK_EN ? 32'h0 : 32'h2010_0005, CHK_EN, "misalign");
    fetch(32'h4 + DEPTH * 4, 32'h2010_0005, 1'b0, "alias");

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      ReqValid  = ($urandom_range(0, 2) != 0);
      ReqAddr   = $urandom;
      if ($urandom_range(0, 1) == 0) ReqAddr[1:0] = 2'b00;
      RespReady = ($urandom_range(0, 1) == 1);
      LoadEn    = ($urandom_range(0, 3) == 0);
      LoadAddr  = $urandom;
      LoadData  = $urandom;
      Reset     = ($urandom_range(0, 59) == 0);
      @(negedge Clk);
    end
    Reset    = 1'b0;
    ReqValid = 1'b0;
    LoadEn   = 1'b0;
    repeat (LAT + 3) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
